// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared widths, limits and types for the BCD decimal decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned DEC_N   = 10;
    localparam int unsigned BCD_MAX = 9;

    typedef logic [BCD_W-1:0] bcd_t;
    typedef logic [DEC_N-1:0] onehot10_t;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module      : bcd_onehot_dec
// Description : Combinational BCD code to one-hot decimal map with invalid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_onehot_dec
    import bcd_pkg::*;
(
    input  bcd_t      i_code,
    output onehot10_t o_onehot,
    output logic      o_invalid
);

    always_comb begin
        o_invalid = (i_code > bcd_t'(BCD_MAX));
        o_onehot  = '0;
        for (int i = 0; i < int'(DEC_N); i++) begin
            o_onehot[i] = (i_code == bcd_t'(i));
        end
    end

endmodule : bcd_onehot_dec
`default_nettype wire

// File: rtl/bcd_to_decimal.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_decimal
// Description : Registered 4-bit BCD to 1-of-10 decoder with invalid flag.
//               Define BCD_ERR_CNT_EN to add a saturating invalid-code counter.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_decimal
    import bcd_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 a,
    input  logic                 b,
    input  logic                 c,
    input  logic                 d,
    output logic                 x0,
    output logic                 x1,
    output logic                 x2,
    output logic                 x3,
    output logic                 x4,
    output logic                 x5,
    output logic                 x6,
    output logic                 x7,
    output logic                 x8,
    output logic                 x9,
    output logic                 out_valid,
    output logic                 invalid
`ifdef BCD_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    bcd_t      w_code;
    onehot10_t w_onehot;
    logic      w_invalid;

    onehot10_t r_x;
    logic      r_out_valid;
    logic      r_invalid;

    assign w_code = {a, b, c, d};

    bcd_onehot_dec u_dec (
        .i_code   (w_code),
        .o_onehot (w_onehot),
        .o_invalid(w_invalid)
    );

    // Decoded state only moves on a valid code, so idle inputs may be X/Z.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= '0;
            r_out_valid <= 1'b0;
            r_invalid   <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_x       <= w_invalid ? '0 : w_onehot;
                r_invalid <= w_invalid;
            end
        end
    end

`ifdef BCD_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Saturates at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (in_valid && w_invalid && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (ERR_CNT_W > 0);
`endif

    assign {x9, x8, x7, x6, x5, x4, x3, x2, x1, x0} = r_x;
    assign out_valid = r_out_valid;
    assign invalid   = r_invalid;

endmodule : bcd_to_decimal
`default_nettype wire

// File: tb/tb_bcd_to_decimal.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_to_decimal
// Description : Self-checking bench: vector table, corner sequences, random run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_decimal;

    localparam int unsigned c_CW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic x0, x1, x2, x3, x4, x5, x6, x7, x8, x9;
    logic out_valid, invalid;
`ifdef BCD_ERR_CNT_EN
    logic [c_CW-1:0] err_cnt;
`endif

    logic [9:0] w_x;
    assign w_x = {x9, x8, x7, x6, x5, x4, x3, x2, x1, x0};

    always #5 clk = ~clk;

    bcd_to_decimal #(.ERR_CNT_W(c_CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .x0       (x0),
        .x1       (x1),
        .x2       (x2),
        .x3       (x3),
        .x4       (x4),
        .x5       (x5),
        .x6       (x6),
        .x7       (x7),
        .x8       (x8),
        .x9       (x9),
        .out_valid(out_valid),
        .invalid  (invalid)
`ifdef BCD_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: last captured code (-1 = none since reset)
    int m_last = -1;
    bit m_ov   = 1'b0;
    bit m_inv  = 1'b0;
    int m_cnt  = 0;

    typedef struct {
        bit         v;
        int         code;
        logic [9:0] ex;
        bit         eov;
        bit         einv;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] model_x();
        if (m_last >= 0 && m_last <= 9) return 10'(1 << m_last);
        return 10'd0;
    endfunction

    task automatic drive(input bit v, input int code);
        in_valid = v;
        {a, b, c, d} = 4'(code);
    endtask

    // One clock with model update; checks everything against the model.
    task automatic step(input string name, input bit v, input int code);
        drive(v, code);
        @(posedge clk);
        #1;
        m_ov = v;
        if (v) begin
            m_last = code;
            m_inv  = (code > 9);
            if (code > 9 && m_cnt < (1 << c_CW) - 1) m_cnt++;
        end
        chk({name, " x"}, 32'(w_x), 32'(model_x()));
        chk({name, " out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({name, " invalid"}, 32'(invalid), 32'(m_inv));
        chk({name, " onehot"}, 32'($countones(w_x) <= 1), 32'd1);
`ifdef BCD_ERR_CNT_EN
        chk({name, " err_cnt"}, 32'(err_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic model_reset();
        m_last = -1; m_ov = 1'b0; m_inv = 1'b0; m_cnt = 0;
    endtask

    initial begin
        // Reset held with a valid code presented
        drive(1'b1, 5);
        repeat (2) @(posedge clk);
        #1;
        chk("reset x", 32'(w_x), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset invalid", 32'(invalid), 32'd0);
`ifdef BCD_ERR_CNT_EN
        chk("reset err_cnt", 32'(err_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        model_reset();
        step("rel x5", 1'b1, 5);
        chk("rel x5 only", 32'(w_x), 32'h020);

        // Table: sweep 0..15, then hold on 7 with idle toggling inputs
        for (int n = 0; n < 16; n++)
            vecs.push_back('{1'b1, n, (n < 10) ? 10'(1 << n) : 10'd0, 1'b1, n >= 10});
        vecs.push_back('{1'b1, 7,  10'h080, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 15, 10'h080, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 0,  10'h080, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 10, 10'h080, 1'b0, 1'b0});
        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].v, vecs[i].code);
            chk($sformatf("tbl%0d x", i), 32'(w_x), 32'(vecs[i].ex));
            chk($sformatf("tbl%0d ov", i), 32'(out_valid), 32'(vecs[i].eov));
            chk($sformatf("tbl%0d inv", i), 32'(invalid), 32'(vecs[i].einv));
        end

        // Back-to-back 3 then 8
        step("b2b 3", 1'b1, 3);
        chk("b2b x3", 32'(w_x), 32'h008);
        step("b2b 8", 1'b1, 8);
        chk("b2b x8", 32'(w_x), 32'h100);

        // Asynchronous reset between edges
        step("pre-rst 9", 1'b1, 9);
        chk("pre-rst x9", 32'(w_x), 32'h200);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst x", 32'(w_x), 32'd0);
        chk("async rst ov", 32'(out_valid), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

`ifdef BCD_ERR_CNT_EN
        begin
            int exp_seq[5] = '{1, 2, 3, 3, 3};
            for (int k = 0; k < 5; k++) begin
                step("cnt 12", 1'b1, 12);
                chk($sformatf("cnt seq%0d", k), 32'(err_cnt), 32'(exp_seq[k]));
            end
            step("cnt valid", 1'b1, 4);
            chk("cnt hold", 32'(err_cnt), 32'd3);
            rst_n = 1'b0;
            #1;
            chk("cnt async rst", 32'(err_cnt), 32'd0);
            model_reset();
            @(negedge clk);
            rst_n = 1'b1;
        end
`endif

        // Randomized run against the model
        for (int k = 0; k < 300; k++)
            step("rand", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bcd_to_decimal
`default_nettype wire

// File: doc/bcd_to_decimal.md
Name: bcd_to_decimal

Overview:
Registered 4-bit BCD to 1-of-10 decimal decoder. The 4-bit input a,b,c,d (a = MSB, weight 8; d = LSB, weight 1) drives exactly one active-high output x0..x9. Codes 10..15 are flagged as invalid. The block feeds display/indicator logic downstream of BCD counters.

Parameters:
ERR_CNT_W, 8, width of the optional invalid-code counter (used only with BCD_ERR_CNT_EN).

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  a,b,c,d carry a code to decode this cycle
a  input  1  BCD bit 3 (weight 8)
b  input  1  BCD bit 2 (weight 4)
c  input  1  BCD bit 1 (weight 2)
d  input  1  BCD bit 0 (weight 1)
x0..x9  output  1 each  one-hot decimal outputs, active high; xN=1 when code==N
out_valid  output  1  x0..x9/invalid updated from a valid input on the previous edge
invalid  output  1  last captured code was 10..15
err_cnt  output  ERR_CNT_W  saturating count of invalid codes (only with BCD_ERR_CNT_EN)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): x0..x9=0, out_valid=0, invalid=0, err_cnt=0. Outputs stay at these values until the first rising edge after rst_n deasserts.
- Code = {a,b,c,d} as an unsigned 4-bit value.
- On a rising edge with in_valid=1:
  - code 0..9: x[code]=1, all other x=0, invalid=0.
  - code 10..15: all x=0, invalid=1.
  - out_valid=1.
- On a rising edge with in_valid=0: x0..x9 and invalid hold their previous values; out_valid=0.
- Latency: exactly 1 clock from input to outputs. There is no combinational path from inputs to outputs.
- Invariant: at most one of x0..x9 is high. x-outputs are all zero exactly when invalid=1 or no valid code has been captured since reset.
- Throughput: a new code is accepted every cycle. There is no backpressure.
- Reset asserted mid-stream clears all outputs immediately, independent of clk. The first valid code after reset release appears 1 cycle after its edge.
- X/Z on a,b,c,d while in_valid=0 has no effect.

Optional Feature:
Macro BCD_ERR_CNT_EN.
- Defined: err_cnt port exists. It increments by 1 on every rising edge with in_valid=1 and code>=10, and saturates at 2^ERR_CNT_W-1 (no wrap). It resets to 0 asynchronously on rst_n=0. The count is registered and updates on the same edge as invalid.
- Not defined: err_cnt port and counter logic are absent. All other behaviour is identical.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_W=4
  - DEC_N=10
  - localparam BCD_MAX=9
  - typedef bcd_t (logic [3:0])
  - typedef onehot10_t (logic [9:0])
- One natural sub-module: bcd_onehot_dec. It is purely combinational, mapping bcd_t to onehot10_t plus an invalid bit. The top level adds the input capture register, valid tracking and the optional counter.

Test Plan:
- Reset: hold rst_n=0 with code 0101 and in_valid=1 -> all x=0, out_valid=0, invalid=0. Release rst_n -> one edge later x5=1 only, out_valid=1.
- Sweep: drive codes 0..15 with in_valid=1, one per cycle -> one cycle later x[N]=1 only for N=0..9. For 10..15, all x=0 and invalid=1. out_valid=1 throughout.
- Hold: capture code 0111, then in_valid=0 for 3 cycles with inputs toggling -> x7 stays 1, out_valid=0, invalid=0.
- Async reset mid-stream: assert rst_n=0 between edges while x9=1 -> x9 drops immediately without a clock edge.
- Counter (BCD_ERR_CNT_EN, ERR_CNT_W=2): apply 5 invalid codes (e.g. 1100) -> err_cnt reads 1,2,3,3,3. Valid codes leave it unchanged.
- Back-to-back: apply 0011 then 1000 on consecutive cycles -> x3=1 then x8=1 on successive cycles, with no cycle where two x are high.
